// File: rtl/alu.sv
// 8-bit registered ALU: eight arithmetic/logic/shift ops with result, zero and
// signed-overflow flags registered together so the flags always describe alu_result.
module alu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] operand1,
  input  logic [7:0] operand2,
  input  logic [2:0] alu_op,
  output logic [7:0] alu_result,
  output logic       zero_flag,
  output logic       overflow_flag
);

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpXor = 3'b100,
    OpNot = 3'b101,
    OpShl = 3'b110,
    OpShr = 3'b111
  } alu_op_e;

  logic [7:0] result_d;
  logic       overflow_d;
  logic [7:0] sum;
  logic [7:0] diff;

  // Carry/borrow out is deliberately dropped; only the mod-256 result matters.
  assign sum  = operand1 + operand2;
  assign diff = operand1 + ~operand2 + 8'd1;

  always_comb begin
    result_d   = 8'h00;
    overflow_d = 1'b0;
    case (alu_op_e'(alu_op))
      OpAdd: begin
        result_d   = sum;
        overflow_d = (operand1[7] == operand2[7]) && (sum[7] != operand1[7]);
      end
      OpSub: begin
        result_d   = diff;
        overflow_d = (operand1[7] != operand2[7]) && (diff[7] != operand1[7]);
      end
      OpAnd:   result_d = operand1 & operand2;
      OpOr:    result_d = operand1 | operand2;
      OpXor:   result_d = operand1 ^ operand2;
      OpNot:   result_d = ~operand1;
      OpShl:   result_d = {operand1[6:0], 1'b0};
      OpShr:   result_d = {1'b0, operand1[7:1]};
      default: result_d = 8'h00;
    endcase
  end

  // Zero comes from result_d so it can never lag the registered result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_result    <= 8'h00;
      zero_flag     <= 1'b1;
      overflow_flag <= 1'b0;
    end else begin
      alu_result    <= result_d;
      zero_flag     <= (result_d == 8'h00);
      overflow_flag <= overflow_d;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed boundary tables, a back-to-back sequence
// with a reset pulse, and randomized ops against an integer-arithmetic model.
module tb_alu;

  logic       clk;
  logic       rst_n;
  logic [7:0] operand1;
  logic [7:0] operand2;
  logic [2:0] alu_op;
  logic [7:0] alu_result;
  logic       zero_flag;
  logic       overflow_flag;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       z;
    logic       v;
  } vec_t;

  alu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .operand1     (operand1),
    .operand2     (operand2),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .zero_flag    (zero_flag),
    .overflow_flag(overflow_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: signed overflow judged by whether the true signed result fits in 8 bits.
  function automatic logic [9:0] model(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    int ia, ib, sa, sb, r, s;
    logic ovf;
    ia  = int'(a);
    ib  = int'(b);
    sa  = (ia >= 128) ? ia - 256 : ia;
    sb  = (ib >= 128) ? ib - 256 : ib;
    ovf = 1'b0;
    r   = 0;
    case (op)
      3'd0: begin r = (ia + ib) % 256;       s = sa + sb; ovf = (s > 127) || (s < -128); end
      3'd1: begin r = (ia - ib + 256) % 256; s = sa - sb; ovf = (s > 127) || (s < -128); end
      3'd2: r = ia & ib;
      3'd3: r = ia | ib;
      3'd4: r = ia ^ ib;
      3'd5: r = 255 - ia;
      3'd6: r = (ia * 2) % 256;
      default: r = ia / 2;
    endcase
    return {ovf, (r == 0), 8'(r)};
  endfunction

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    alu_op   = op;
    operand1 = a;
    operand2 = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(3'd0, 8'hAA, 8'h55);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if ({alu_result, zero_flag, overflow_flag} !== {8'h00, 1'b1, 1'b0}) begin
        tests_failed++;
        $display("FAIL reset[%0d]: got r=%02h z=%0b v=%0b want r=00 z=1 v=0",
                 i, alu_result, zero_flag, overflow_flag);
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({alu_result, zero_flag, overflow_flag} !== {8'hFF, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_release: got r=%02h z=%0b v=%0b want r=ff z=0 v=0",
               alu_result, zero_flag, overflow_flag);
    end
  endtask

  // Directed table with spec-derived constants; one registered result per edge.
  task automatic run_table(input string name, input vec_t v[]);
    foreach (v[i]) begin
      drive(v[i].op, v[i].a, v[i].b);
      @(posedge clk);
      #1;
      tests_run++;
      if ({alu_result, zero_flag, overflow_flag} !== {v[i].r, v[i].z, v[i].v}) begin
        tests_failed++;
        $display("FAIL %s[%0d]: got r=%02h z=%0b v=%0b want r=%02h z=%0b v=%0b", name, i,
                 alu_result, zero_flag, overflow_flag, v[i].r, v[i].z, v[i].v);
      end
    end
  endtask

  task automatic test_add();
    vec_t v[] = '{'{3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1},
                  '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0},
                  '{3'd0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1}};
    run_table("add", v);
  endtask

  task automatic test_sub();
    vec_t v[] = '{'{3'd1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1},
                  '{3'd1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0},
                  '{3'd1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0}};
    run_table("sub", v);
  endtask

  task automatic test_logic();
    vec_t v[] = '{'{3'd2, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0},
                  '{3'd3, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0},
                  '{3'd4, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0},
                  '{3'd5, 8'h00, 8'h3C, 8'hFF, 1'b0, 1'b0}};
    run_table("logic", v);
  endtask

  task automatic test_shift();
    vec_t v[] = '{'{3'd6, 8'h81, 8'hFF, 8'h02, 1'b0, 1'b0},
                  '{3'd7, 8'h81, 8'hFF, 8'h40, 1'b0, 1'b0},
                  '{3'd6, 8'h80, 8'h00, 8'h00, 1'b1, 1'b0}};
    run_table("shift", v);
  endtask

  // Checks outputs still hold the previous result mid-cycle, then the new one after
  // the edge; a reset pulse in step 2 must affect that single cycle only.
  task automatic test_back_to_back();
    logic [2:0] ops[6] = '{3'd0, 3'd1, 3'd4, 3'd7, 3'd0, 3'd1};
    logic [9:0] prev, exp;
    prev = {overflow_flag, zero_flag, alu_result};
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], 8'($urandom), 8'($urandom));
      rst_n = (i != 2);
      exp   = (i == 2) ? {1'b0, 1'b1, 8'h00} : model(alu_op, operand1, operand2);
      @(negedge clk);
      tests_run++;
      if ({overflow_flag, zero_flag, alu_result} !== prev) begin
        tests_failed++;
        $display("FAIL b2b_hold[%0d]: got v/z/r=%b want %b", i,
                 {overflow_flag, zero_flag, alu_result}, prev);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if ({overflow_flag, zero_flag, alu_result} !== exp) begin
        tests_failed++;
        $display("FAIL b2b[%0d]: got v/z/r=%b want %b", i,
                 {overflow_flag, zero_flag, alu_result}, exp);
      end
      prev = exp;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [9:0] exp;
    for (int i = 0; i < 400; i++) begin
      drive(3'($urandom), 8'($urandom), (i % 8 == 0) ? operand1 : 8'($urandom));
      exp = model(alu_op, operand1, operand2);
      @(posedge clk);
      #1;
      tests_run++;
      if ({overflow_flag, zero_flag, alu_result} !== exp) begin
        tests_failed++;
        $display("FAIL random[%0d] op=%0d a=%02h b=%02h: got v/z/r=%b want %b", i, alu_op,
                 operand1, operand2, {overflow_flag, zero_flag, alu_result}, exp);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    drive(3'd0, 8'h00, 8'h00);
    #2;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_shift();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
